demux_stream_1ton: RTL and testbench
====================================

# demux_stream_1toN

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshakes on the input and on every output channel. It is the successor of the plain two-output demux, generalised in data width and channel count. It adds a broadcast mode, per-channel backpressure, a one-entry holding stage, and a saturating error counter for out-of-range selects. It sits between a single producer and N independent consumers in the datapath.

## Interface
- WIDTH, 8: data width per channel, ≥1.
- N, 4: number of output channels, 2..16.
- SEL_W, 2: width of in_sel; must satisfy 2^SEL_W ≥ N.
- CNT_W, 8: width of err_cnt.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  1 = deliver word to all N channels (in_sel ignored).
- out_valid  out  N  bit i = channel i holds a word.
- out_ready  in  N  bit i = consumer i accepts this cycle.
- out_data  out  N*WIDTH  lane i is bits [i*WIDTH +: WIDTH].
- busy  out  1  any channel pending (|pend_q).
- err_cnt  out  CNT_W  count of dropped out-of-range words, saturating.

## Operation
- State: data_q (WIDTH), pend_q (N-bit pending mask), err_cnt.
- Two states, derived from pend_q:
  - EMPTY: pend_q == 0.
  - HOLD: pend_q != 0.
- out_valid = pend_q.
- out_data lane i = data_q when pend_q[i], else all zeros. Unselected outputs are driven to 0, as in the 1:2 demux.
- Output handshake on channel i: out_valid[i] & out_ready[i]. Completing it clears pend_q[i] at the next edge.
- pend_next = pend_q & ~(out_valid & out_ready).
- in_ready = ~rst & (pend_next == 0). Combinational. A new word is accepted in the same cycle the last pending channel drains.
- Input accept (in_valid & in_ready):
  - in_bcast = 1: data_q ← in_data; pend_q ← all ones.
  - in_bcast = 0 and in_sel < N: data_q ← in_data; pend_q ← one-hot(in_sel).
  - in_bcast = 0 and in_sel ≥ N: word dropped; pend_q ← 0; data_q unchanged; err_cnt ← err_cnt + 1, saturating at 2^CNT_W − 1.
- No accept: pend_q ← pend_next; data_q holds.
- Broadcast completes only when every channel has handshaken. Channels may drain in any order and in different cycles. Only the remaining pending channels still present the word.
- in_valid with in_ready = 0: no state change. The producer must hold in_data, in_sel and in_bcast stable until accepted.
- out_ready on a channel whose out_valid is 0 is ignored.

## Timing
- Reset (rst = 1 at an edge):
  - pend_q = 0, data_q = 0, err_cnt = 0.
  - Hence out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after reset is released.
- Reset mid-operation discards any pending word, including a partially drained broadcast. Pending words are not flushed to outputs.
- Latency: word accepted at edge k is visible on out_valid and out_data from edge k, i.e. in the cycle after the handshake cycle.
- Throughput: one word per cycle when the destination consumer(s) keep out_ready high.
- Simultaneous output drain and input accept in one cycle:
  - The drain clears the old mask and the new mask loads at the same edge.
  - Back-to-back words to the same channel produce no bubble.
- Out-of-range drops take one input cycle each. in_ready stays governed by pend_next only.
- err_cnt increments one edge after the dropping handshake. Once saturated, it holds until rst.

## Test plan
- Reset then idle, N = 4, WIDTH = 8:
  - During reset: in_ready = 0.
  - After release: in_ready = 1, out_valid = 4'b0000, out_data = 0, err_cnt = 0.
- Unicast: send 0xA5 to sel = 2 with out_ready = 4'b1111.
  - Next cycle: out_valid = 4'b0100, lane 2 = 0xA5, other lanes 0.
  - Following cycle: out_valid = 0.
- Backpressure: send 0x3C to sel = 1 with out_ready[1] = 0 for 3 cycles.
  - out_valid[1] holds 0x3C and in_ready = 0 for those 3 cycles.
  - Raising out_ready[1] lets a second word 0x11 to sel = 1 be accepted in that same cycle; it appears with no bubble.
- Broadcast: send 0x77 with in_bcast = 1; drive out_ready = 4'b0001, then 4'b0110, then 4'b1000.
  - out_valid steps 1111 → 1110 → 1000 → 0000.
  - in_ready rises only in the third drain cycle.
- Out-of-range: N = 3, SEL_W = 2, sel = 3, five words.
  - No out_valid at any point; err_cnt = 5.
  - With CNT_W = 2, err_cnt saturates at 3.
- Reset mid-broadcast: assert rst with out_valid = 4'b1010.
  - Next cycle: out_valid = 0, busy = 0, err_cnt = 0.

Source files
------------

// File: rtl/demux_stream_1ton_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer-facing input
// channel and N consumer-facing output channels, each with valid/ready.
interface demux_stream_1ton_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_bcast;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;

    // Environment side: drives the producer inputs and the consumer readies.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with broadcast, per-channel
// backpressure, a one-entry holding stage and a saturating drop counter
// for out-of-range channel selects.
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux_stream_1ton_if.slave  bus,
    output logic                busy,
    output logic [CNT_W-1:0]    err_cnt
);

    // EMPTY/HOLD is fully implied by the pending mask; no separate state flop.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    logic [WIDTH-1:0] data_q, data_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [N-1:0]     pend_next;
    logic [N-1:0]     sel_onehot;
    logic             in_ready;
    logic             accept;
    state_e           state;

    // Decode in_sel; an all-zero result means the select is out of range.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sel_onehot[i] = (bus.in_sel == SEL_W'(i));
        end
    end

    // Drain the pending mask, decide acceptance and compute the next state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        pend_next = pend_q & ~(pend_q & bus.out_ready);
        in_ready  = ~rst & (pend_next == '0);
        accept    = bus.in_valid & in_ready;
        pend_d    = pend_next;
        data_d    = data_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (bus.in_bcast) begin
                pend_d = '1;
                data_d = bus.in_data;
            end else if (|sel_onehot) begin
                pend_d = sel_onehot;
                data_d = bus.in_data;
            end else begin
                // Dropped word: nothing becomes pending, data register keeps its value.
                pend_d = '0;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset; a reset discards any pending word.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: data_q is a single word, so clearing it is cheap and keeps out_data at 0 after reset.
            data_q    <= '0;
            pend_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            pend_q    <= pend_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs: valid straight from the pending mask, idle lanes forced to zero.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) begin
                bus.out_data[i*WIDTH +: WIDTH] = data_q;
            end
        end
        bus.out_valid = pend_q;
        bus.in_ready  = in_ready;
        state         = (pend_q == '0) ? S_EMPTY : S_HOLD;
        busy          = (state == S_HOLD);
        err_cnt       = err_cnt_q;
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: directed vectors on an N=4 instance with a
// per-channel scoreboard, plus two N=3 instances for out-of-range drops
// (one with a 2-bit counter to reach saturation).
module tb_demux_stream_1ton;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_stream_1ton_if #(.WIDTH(8), .N(4), .SEL_W(2)) a_if ();
    demux_stream_1ton_if #(.WIDTH(8), .N(3), .SEL_W(2)) b_if ();
    demux_stream_1ton_if #(.WIDTH(8), .N(3), .SEL_W(2)) c_if ();

    logic       a_busy, b_busy, c_busy;
    logic [7:0] a_err;
    logic [1:0] b_err;
    logic [7:0] c_err;

    demux_stream_1ton #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .busy(a_busy), .err_cnt(a_err));
    demux_stream_1ton #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .busy(b_busy), .err_cnt(b_err));
    demux_stream_1ton #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .bus(c_if), .busy(c_busy), .err_cnt(c_err));

    int n_vec = 0;
    int n_bad = 0;

    // Expected words per channel of dut_a, pushed when stimulus is issued.
    logic [7:0] exp_q [4][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [1:0] sel, input logic bcast, input logic [7:0] d);
        if (bcast) begin
            for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
        end else begin
            exp_q[sel].push_back(d);
        end
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic bcast, input logic [7:0] d);
        a_if.in_valid = v;
        a_if.in_sel   = sel;
        a_if.in_bcast = bcast;
        a_if.in_data  = d;
    endtask

    task automatic drive_bc(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic [2:0] rdy);
        b_if.in_valid = v;  c_if.in_valid = v;
        b_if.in_sel   = sel; c_if.in_sel  = sel;
        b_if.in_bcast = 1'b0; c_if.in_bcast = 1'b0;
        b_if.in_data  = d;  c_if.in_data  = d;
        b_if.out_ready = rdy; c_if.out_ready = rdy;
    endtask

    // Monitor: every output handshake on dut_a pops and compares its channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (a_if.out_valid[i] && a_if.out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_word_ch%0d", i), 32'(a_if.out_data[i*8 +: 8]), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("data_ch%0d", i), 32'(a_if.out_data[i*8 +: 8]), 32'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus and cycle-exact checks.
    initial begin
        drive_a(1'b0, 2'd0, 1'b0, 8'h00);
        a_if.out_ready = 4'b0000;
        drive_bc(1'b0, 2'd0, 8'h00, 3'b000);

        // Reset, then idle.
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(a_if.in_ready), 32'd0);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(a_if.in_ready), 32'd1);
        check("idle_out_valid", 32'(a_if.out_valid), 32'd0);
        check("idle_out_data", a_if.out_data, 32'd0);
        check("idle_err_cnt", 32'(a_err), 32'd0);
        tick();

        // Unicast 0xA5 to channel 2.
        a_if.out_ready = 4'b1111;
        drive_a(1'b1, 2'd2, 1'b0, 8'hA5);
        push_a(2'd2, 1'b0, 8'hA5);
        @(negedge clk);
        check("uni_in_ready", 32'(a_if.in_ready), 32'd1);
        tick();
        a_if.in_valid = 1'b0;
        @(negedge clk);
        check("uni_out_valid", 32'(a_if.out_valid), 32'h4);
        check("uni_out_data", a_if.out_data, 32'h00A5_0000);
        check("uni_busy", 32'(a_busy), 32'd1);
        tick();
        @(negedge clk);
        check("uni_drained", 32'(a_if.out_valid), 32'd0);
        tick();

        // Backpressure on channel 1 for three cycles, then a no-bubble follow-up.
        a_if.out_ready = 4'b1101;
        drive_a(1'b1, 2'd1, 1'b0, 8'h3C);
        push_a(2'd1, 1'b0, 8'h3C);
        tick();
        drive_a(1'b1, 2'd1, 1'b0, 8'h11);
        push_a(2'd1, 1'b0, 8'h11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_out_valid_%0d", k), 32'(a_if.out_valid), 32'h2);
            check($sformatf("bp_out_data_%0d", k), a_if.out_data, 32'h0000_3C00);
            check($sformatf("bp_in_ready_%0d", k), 32'(a_if.in_ready), 32'd0);
            tick();
        end
        a_if.out_ready = 4'b1111;
        @(negedge clk);
        check("bp_release_in_ready", 32'(a_if.in_ready), 32'd1);
        tick();
        a_if.in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", 32'(a_if.out_valid), 32'h2);
        check("bp_second_data", a_if.out_data, 32'h0000_1100);
        tick();
        @(negedge clk);
        check("bp_drained", 32'(a_if.out_valid), 32'd0);
        tick();

        // Back-to-back words to channel 0 at full throughput.
        for (int w = 1; w <= 3; w++) begin
            drive_a(1'b1, 2'd0, 1'b0, 8'(w));
            push_a(2'd0, 1'b0, 8'(w));
            @(negedge clk);
            check($sformatf("b2b_in_ready_%0d", w), 32'(a_if.in_ready), 32'd1);
            if (w > 1) check($sformatf("b2b_valid_%0d", w), 32'(a_if.out_valid), 32'h1);
            tick();
        end
        a_if.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", 32'(a_if.out_valid), 32'h1);
        check("b2b_last_data", a_if.out_data, 32'h0000_0003);
        tick();

        // Broadcast 0x77 drained in three steps; in_sel is ignored.
        a_if.out_ready = 4'b0000;
        drive_a(1'b1, 2'd3, 1'b1, 8'h77);
        push_a(2'd0, 1'b1, 8'h77);
        tick();
        drive_a(1'b0, 2'd0, 1'b0, 8'h00);
        a_if.out_ready = 4'b0001;
        @(negedge clk);
        check("bc_valid_1111", 32'(a_if.out_valid), 32'hF);
        check("bc_data_all", a_if.out_data, 32'h7777_7777);
        check("bc_in_ready_0", 32'(a_if.in_ready), 32'd0);
        tick();
        a_if.out_ready = 4'b0110;
        @(negedge clk);
        check("bc_valid_1110", 32'(a_if.out_valid), 32'hE);
        check("bc_data_1110", a_if.out_data, 32'h7777_7700);
        check("bc_in_ready_1", 32'(a_if.in_ready), 32'd0);
        tick();
        a_if.out_ready = 4'b1000;
        @(negedge clk);
        check("bc_valid_1000", 32'(a_if.out_valid), 32'h8);
        check("bc_in_ready_2", 32'(a_if.in_ready), 32'd1);
        tick();
        a_if.out_ready = 4'b0000;
        @(negedge clk);
        check("bc_valid_0000", 32'(a_if.out_valid), 32'd0);
        check("bc_busy", 32'(a_busy), 32'd0);
        tick();

        // Reset in the middle of a partially drained broadcast.
        drive_a(1'b1, 2'd0, 1'b1, 8'h5A);
        push_a(2'd0, 1'b1, 8'h5A);
        tick();
        drive_a(1'b0, 2'd0, 1'b0, 8'h00);
        a_if.out_ready = 4'b0101;
        @(negedge clk);
        check("mr_valid_1111", 32'(a_if.out_valid), 32'hF);
        tick();
        a_if.out_ready = 4'b0000;
        @(negedge clk);
        check("mr_valid_1010", 32'(a_if.out_valid), 32'hA);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mr_in_ready_in_rst", 32'(a_if.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        exp_q[1].delete();
        exp_q[3].delete();
        @(negedge clk);
        check("mr_out_valid", 32'(a_if.out_valid), 32'd0);
        check("mr_out_data", a_if.out_data, 32'd0);
        check("mr_busy", 32'(a_busy), 32'd0);
        check("mr_err_cnt", 32'(a_err), 32'd0);
        check("mr_in_ready", 32'(a_if.in_ready), 32'd1);
        tick();

        // Out-of-range selects on N=3 instances: five drops.
        for (int k = 0; k < 5; k++) begin
            drive_bc(1'b1, 2'd3, 8'(8'hC0 + k), 3'b111);
            @(negedge clk);
            check($sformatf("oor_b_in_ready_%0d", k), 32'(b_if.in_ready), 32'd1);
            check($sformatf("oor_b_valid_%0d", k), 32'(b_if.out_valid), 32'd0);
            check($sformatf("oor_c_valid_%0d", k), 32'(c_if.out_valid), 32'd0);
            check($sformatf("oor_b_err_%0d", k), 32'(b_err), (k > 3) ? 32'd3 : 32'(k));
            check($sformatf("oor_c_err_%0d", k), 32'(c_err), 32'(k));
            tick();
        end
        // An in-range word afterwards still goes through; counters hold.
        drive_bc(1'b1, 2'd2, 8'h9E, 3'b000);
        @(negedge clk);
        check("oor_b_err_sat", 32'(b_err), 32'd3);
        check("oor_c_err_5", 32'(c_err), 32'd5);
        check("oor_b_busy", 32'(b_busy), 32'd0);
        tick();
        drive_bc(1'b0, 2'd0, 8'h00, 3'b000);
        @(negedge clk);
        check("inr_c_valid", 32'(c_if.out_valid), 32'h4);
        check("inr_c_data", 32'(c_if.out_data), 32'h009E_0000);
        check("inr_b_valid", 32'(b_if.out_valid), 32'h4);
        check("inr_c_err_hold", 32'(c_err), 32'd5);
        check("inr_b_err_hold", 32'(b_err), 32'd3);
        check("inr_c_busy", 32'(c_busy), 32'd1);
        tick();
        drive_bc(1'b0, 2'd0, 8'h00, 3'b111);
        tick();
        @(negedge clk);
        check("inr_c_drained", 32'(c_if.out_valid), 32'd0);
        tick();

        // Every issued word on dut_a must have been delivered.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("leftover_ch%0d", i), 32'(exp_q[i].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
